cache_controller: RTL and testbench
===================================

# cache_controller

Sequencing FSM for the direct-mapped cache datapath: accepts read requests from the cpu, drives the tag/data array lookup, and on a miss fetches the block from main memory and writes it back into the array. It also keeps the access and hit statistics. The block sits between cpu, cacheMemory's tag/data array and main_memory, and replaces ad-hoc ready/memRead glue with a single owner of the miss sequence.

## Interface
- ADDR_WIDTH, 15, cpu word address width
- TAG_WIDTH, 3, tag field width (address[14:12])
- OFFSET_WIDTH, 2, word-in-block field width (address[1:0])
- COUNT_WIDTH, 14, statistics counter width
- Index width is derived: ADDR_WIDTH-TAG_WIDTH-OFFSET_WIDTH = 10 (1024 blocks).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_read  in  1  request strobe, sampled only in IDLE
- cpu_address  in  15  request address, latched with an accepted cpu_read
- clear_stats  in  1  synchronous clear of both counters
- cache_ready  out  1  one-cycle completion pulse
- cpu_hit  out  1  hit/miss result, valid only while cache_ready=1
- lookup_en  out  1  one-cycle array lookup strobe
- lookup_index  out  10  latched index field
- lookup_tag  out  3  latched tag field
- array_hit  in  1  array compare result, valid the cycle after lookup_en
- mem_read  out  1  memory block-read request, level
- mem_address  out  15  {tag, index, 2'b00}
- mem_ready  in  1  memory block data valid; sampled only in MEM_WAIT
- refill_en  out  1  one-cycle write of the memory block, tag and valid=1 at lookup_index
- access_count  out  14  completed accesses, saturating
- hit_count  out  14  completed hits, saturating

## Operation
- States: IDLE, LOOKUP, COMPARE, MEM_WAIT, REFILL, DONE.
- IDLE: on cpu_read=1, latch cpu_address and go to LOOKUP. Otherwise stay in IDLE.
- LOOKUP: lookup_en=1, then go to COMPARE.
- COMPARE: sample array_hit.
  - If 1: set the hit flag and go to DONE.
  - If 0: clear the hit flag and go to MEM_WAIT.
- MEM_WAIT: mem_read=1 in every cycle of this state. When mem_ready=1 is sampled, go to REFILL. Wait is unbounded.
- REFILL: refill_en=1, then go to DONE.
- DONE: cache_ready=1 and cpu_hit=hit flag. Update the counters, then go to IDLE.
- All outputs are decoded from registered state and the latched address, so no output depends combinationally on an input.
- Latched address is stable from LOOKUP through DONE. cpu_address changes after acceptance are ignored.
- cpu_read outside IDLE is ignored; there is no queueing. If cpu_read is held high, the next request is accepted in the IDLE cycle that follows DONE.
- mem_ready outside MEM_WAIT and array_hit outside COMPARE are ignored.
- Counters:
  - In DONE, access_count increments by 1, and hit_count increments by 1 if the hit flag is set.
  - Each counter saturates at 16383 independently and never wraps.
- clear_stats=1 zeroes both counters next edge. It takes priority over a simultaneous DONE increment.

## Timing
- Reset (async assert): state=IDLE. cache_ready, cpu_hit, lookup_en, mem_read, refill_en, access_count and hit_count are 0. lookup_index, lookup_tag and mem_address are 0.
- Reset mid-operation aborts the access with no completion pulse and no counter update. mem_read drops immediately.
- Cycle numbering below: cpu_read sampled at edge 0.
- Hit: lookup_en in cycle 1, array_hit sampled at end of cycle 2, cache_ready+cpu_hit in cycle 3. Hit latency is 3 cycles; next accept is at the end of cycle 4.
- Miss: mem_read goes high in cycle 3.
  - mem_ready first sampled in cycle 3+k (k≥0).
  - refill_en in cycle 4+k, cache_ready with cpu_hit=0 in cycle 5+k.
  - Minimum miss latency is 5 cycles.
- Counter values reflect a DONE cycle starting on the following cycle.

## Test plan
- Hit: cpu_read, cpu_address=15'h1234, with array_hit=1 in COMPARE -> lookup_en cycle 1 with index=10'h08D and tag=3'h1; cache_ready=1 and cpu_hit=1 in cycle 3; access_count=1 and hit_count=1; mem_read never asserts.
- Miss, memory latency 4: address 15'h7FFF, array_hit=0, mem_ready at 4th mem_read cycle -> mem_read high cycles 3–6 with mem_address=15'h7FFC; refill_en cycle 7; cache_ready cycle 8 with cpu_hit=0; access_count=1, hit_count=0.
- Immediate mem_ready (k=0) -> refill_en cycle 4, cache_ready cycle 5. cpu_read pulses and address changes during the access do not alter lookup_index, lookup_tag or mem_address, and do not start a second access.
- Back-to-back: cpu_read held high across two hits -> cache_ready in cycles 3 and 7; access_count=2.
- Saturation: force 16384+ hit accesses (or preload via long run) -> both counters stick at 16383. clear_stats asserted in a DONE cycle -> both counters read 0 the next cycle.
- Reset: assert rst in cycle 5 of a miss (MEM_WAIT) -> mem_read=0 in the same cycle; no cache_ready; counters 0. A following hit request completes normally in 3 cycles.

Source files
------------

// File: rtl/cache_controller_if.sv
// Bus bundle between the cache controller and its cpu, tag/data array and main memory.
// The master side is the surrounding system; the slave side is the controller.
interface cache_controller_if #(
  parameter int ADDR_WIDTH   = 15,
  parameter int TAG_WIDTH    = 3,
  parameter int OFFSET_WIDTH = 2,
  parameter int COUNT_WIDTH  = 14
);
  localparam int INDEX_WIDTH = ADDR_WIDTH - TAG_WIDTH - OFFSET_WIDTH;

  logic                   cpu_read;
  logic [ADDR_WIDTH-1:0]  cpu_address;
  logic                   clear_stats;
  logic                   cache_ready;
  logic                   cpu_hit;
  logic                   lookup_en;
  logic [INDEX_WIDTH-1:0] lookup_index;
  logic [TAG_WIDTH-1:0]   lookup_tag;
  logic                   array_hit;
  logic                   mem_read;
  logic [ADDR_WIDTH-1:0]  mem_address;
  logic                   mem_ready;
  logic                   refill_en;
  logic [COUNT_WIDTH-1:0] access_count;
  logic [COUNT_WIDTH-1:0] hit_count;

  modport master (
    output cpu_read, cpu_address, clear_stats, array_hit, mem_ready,
    input  cache_ready, cpu_hit, lookup_en, lookup_index, lookup_tag,
           mem_read, mem_address, refill_en, access_count, hit_count
  );

  modport slave (
    input  cpu_read, cpu_address, clear_stats, array_hit, mem_ready,
    output cache_ready, cpu_hit, lookup_en, lookup_index, lookup_tag,
           mem_read, mem_address, refill_en, access_count, hit_count
  );
endinterface

// File: rtl/cache_controller.sv
// Miss-sequencing FSM for the direct-mapped cache: lookup, memory block fetch, refill,
// completion pulse, plus saturating access/hit statistics.
module cache_controller #(
  parameter int ADDR_WIDTH   = 15,
  parameter int TAG_WIDTH    = 3,
  parameter int OFFSET_WIDTH = 2,
  parameter int COUNT_WIDTH  = 14
) (
  input logic               clk,
  input logic               rst,
  cache_controller_if.slave bus
);
  localparam int INDEX_WIDTH = ADDR_WIDTH - TAG_WIDTH - OFFSET_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COMPARE,
    MEM_WAIT,
    REFILL,
    DONE
  } state_t;

  state_t                 state;
  logic                   hit_flag;
  logic                   cache_ready;
  logic                   cpu_hit;
  logic                   lookup_en;
  logic                   mem_read;
  logic                   refill_en;
  logic [INDEX_WIDTH-1:0] lookup_index;
  logic [TAG_WIDTH-1:0]   lookup_tag;
  logic [COUNT_WIDTH-1:0] access_count;
  logic [COUNT_WIDTH-1:0] hit_count;

  // Outputs are registered on the transition into the state that owns them,
  // so each strobe is high exactly for the cycle spent in that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hit_flag     <= 1'b0;
      cache_ready  <= 1'b0;
      cpu_hit      <= 1'b0;
      lookup_en    <= 1'b0;
      mem_read     <= 1'b0;
      refill_en    <= 1'b0;
      lookup_index <= '0;
      lookup_tag   <= '0;
    end else begin
      lookup_en   <= 1'b0;
      refill_en   <= 1'b0;
      cache_ready <= 1'b0;
      cpu_hit     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_read) begin
            lookup_tag   <= bus.cpu_address[ADDR_WIDTH-1 -: TAG_WIDTH];
            lookup_index <= bus.cpu_address[OFFSET_WIDTH +: INDEX_WIDTH];
            lookup_en    <= 1'b1;
            state        <= LOOKUP;
          end
        end
        LOOKUP: state <= COMPARE;
        COMPARE: begin
          if (bus.array_hit) begin
            hit_flag    <= 1'b1;
            cache_ready <= 1'b1;
            cpu_hit     <= 1'b1;
            state       <= DONE;
          end else begin
            hit_flag <= 1'b0;
            mem_read <= 1'b1;
            state    <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            mem_read  <= 1'b0;
            refill_en <= 1'b1;
            state     <= REFILL;
          end
        end
        REFILL: begin
          cache_ready <= 1'b1;
          cpu_hit     <= hit_flag;
          state       <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // clear_stats wins over a same-cycle DONE increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      access_count <= '0;
      hit_count    <= '0;
    end else if (bus.clear_stats) begin
      access_count <= '0;
      hit_count    <= '0;
    end else if (state == DONE) begin
      if (access_count != '1)
        access_count <= access_count + COUNT_WIDTH'(1);
      if (hit_flag && (hit_count != '1))
        hit_count <= hit_count + COUNT_WIDTH'(1);
    end
  end

  assign bus.cache_ready  = cache_ready;
  assign bus.cpu_hit      = cpu_hit;
  assign bus.lookup_en    = lookup_en;
  assign bus.lookup_index = lookup_index;
  assign bus.lookup_tag   = lookup_tag;
  assign bus.mem_read     = mem_read;
  assign bus.mem_address  = {lookup_tag, lookup_index, {OFFSET_WIDTH{1'b0}}};
  assign bus.refill_en    = refill_en;
  assign bus.access_count = access_count;
  assign bus.hit_count    = hit_count;
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: table vectors, randomized accesses against a
// timeline/statistics reference model, and hand-written multi-cycle corner sequences.
module tb_cache_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;

  cache_controller_if #(.ADDR_WIDTH(15), .TAG_WIDTH(3), .OFFSET_WIDTH(2), .COUNT_WIDTH(14)) bus ();

  cache_controller #(
    .ADDR_WIDTH(15),
    .TAG_WIDTH(3),
    .OFFSET_WIDTH(2),
    .COUNT_WIDTH(14)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned m_acc = 0;
  int unsigned m_hit = 0;
  localparam int unsigned SAT = 16383;

  typedef struct {
    logic [14:0] addr;
    bit          hit;
    int unsigned k;
    logic [9:0]  e_idx;
    logic [2:0]  e_tag;
    logic [14:0] e_mem;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete access starting from IDLE; every cycle is checked against the
  // timeline implied by hit/k, and junk is driven on all inputs that must be ignored.
  task automatic run_access(input string nm, input logic [14:0] addr, input bit hit,
                            input int unsigned k, input logic [9:0] e_idx,
                            input logic [2:0] e_tag, input logic [14:0] e_mem);
    int unsigned lat;
    lat = hit ? 3 : 5 + k;
    @(negedge clk);
    bus.cpu_read    = 1'b1;
    bus.cpu_address = addr;
    bus.array_hit   = 1'($urandom);
    bus.mem_ready   = 1'($urandom);
    for (int unsigned c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      chk({nm, "_lookup_en"}, bus.lookup_en, c == 1);
      chk({nm, "_mem_read"}, bus.mem_read, !hit && c >= 3 && c <= 3 + k);
      chk({nm, "_refill_en"}, bus.refill_en, !hit && c == 4 + k);
      chk({nm, "_cache_ready"}, bus.cache_ready, c == lat);
      chk({nm, "_cpu_hit"}, bus.cpu_hit, c == lat && hit);
      chk({nm, "_index"}, bus.lookup_index, e_idx);
      chk({nm, "_tag"}, bus.lookup_tag, e_tag);
      chk({nm, "_mem_address"}, bus.mem_address, e_mem);
      if (c == lat + 1) begin
        if (m_acc < SAT) m_acc++;
        if (hit && m_hit < SAT) m_hit++;
        chk({nm, "_access_count"}, bus.access_count, m_acc);
        chk({nm, "_hit_count"}, bus.hit_count, m_hit);
        bus.cpu_read = 1'b0;
      end else begin
        bus.cpu_read = 1'($urandom);
      end
      bus.cpu_address = 15'($urandom);
      bus.array_hit   = (c == 2) ? hit : 1'($urandom);
      if (!hit && c >= 3 && c <= 3 + k) bus.mem_ready = (c == 3 + k);
      else bus.mem_ready = 1'($urandom);
    end
  endtask

  initial begin
    logic [14:0] a;
    bit          h;
    int unsigned kk;

    tbl[0] = '{15'h1234, 1'b1, 0, 10'h08D, 3'h1, 15'h1234};
    tbl[1] = '{15'h7FFF, 1'b0, 3, 10'h3FF, 3'h7, 15'h7FFC};
    tbl[2] = '{15'h0000, 1'b0, 0, 10'h000, 3'h0, 15'h0000};
    tbl[3] = '{15'h5A5A, 1'b1, 0, 10'h296, 3'h5, 15'h5A58};

    bus.cpu_read    = 1'b0;
    bus.cpu_address = '0;
    bus.clear_stats = 1'b0;
    bus.array_hit   = 1'b0;
    bus.mem_ready   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cache_ready", bus.cache_ready, 0);
    chk("rst_cpu_hit", bus.cpu_hit, 0);
    chk("rst_lookup_en", bus.lookup_en, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_refill_en", bus.refill_en, 0);
    chk("rst_index", bus.lookup_index, 0);
    chk("rst_tag", bus.lookup_tag, 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_access_count", bus.access_count, 0);
    chk("rst_hit_count", bus.hit_count, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      run_access("tbl", tbl[i].addr, tbl[i].hit, tbl[i].k, tbl[i].e_idx, tbl[i].e_tag, tbl[i].e_mem);

    for (int i = 0; i < 40; i++) begin
      a  = 15'($urandom);
      h  = 1'($urandom);
      kk = $urandom_range(0, 6);
      run_access("rnd", a, h, kk, 10'((a / 4) % 1024), 3'(a / 4096), a - (a % 4));
    end

    // cpu_read held high across two hits
    @(negedge clk);
    bus.cpu_read    = 1'b1;
    bus.cpu_address = 15'h0ABC;
    bus.array_hit   = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("b2b_cache_ready", bus.cache_ready, c == 3 || c == 7);
      chk("b2b_mem_read", bus.mem_read, 0);
      if (c == 7) bus.cpu_read = 1'b0;
      if (c == 8) begin
        m_acc += 2;
        m_hit += 2;
        chk("b2b_access_count", bus.access_count, m_acc);
        chk("b2b_hit_count", bus.hit_count, m_hit);
      end
    end

    // saturation from zero with a long run of hits
    bus.clear_stats = 1'b1;
    @(negedge clk);
    bus.clear_stats = 1'b0;
    bus.cpu_read    = 1'b1;
    bus.array_hit   = 1'b1;
    repeat (4 * 16390) @(negedge clk);
    bus.cpu_read = 1'b0;
    repeat (8) @(negedge clk);
    m_acc = SAT;
    m_hit = SAT;
    chk("sat_access_count", bus.access_count, m_acc);
    chk("sat_hit_count", bus.hit_count, m_hit);

    // clear_stats coinciding with DONE
    @(negedge clk);
    bus.cpu_read    = 1'b1;
    bus.cpu_address = 15'h1111;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.cpu_read  = 1'b0;
      bus.array_hit = (c == 2);
      if (c == 3) begin
        chk("clr_cache_ready", bus.cache_ready, 1);
        bus.clear_stats = 1'b1;
      end
      if (c == 4) begin
        m_acc = 0;
        m_hit = 0;
        chk("clr_access_count", bus.access_count, 0);
        chk("clr_hit_count", bus.hit_count, 0);
        bus.clear_stats = 1'b0;
      end
    end

    run_access("pre", 15'h0F0F, 1'b1, 0, 10'h3C3, 3'h0, 15'h0F0C);

    // reset in cycle 5 of a miss
    @(negedge clk);
    bus.cpu_read    = 1'b1;
    bus.cpu_address = 15'h2468;
    bus.array_hit   = 1'b0;
    bus.mem_ready   = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.cpu_read = 1'b0;
    end
    chk("mid_mem_read_before", bus.mem_read, 1);
    rst = 1'b1;
    #1;
    chk("mid_mem_read", bus.mem_read, 0);
    chk("mid_access_count", bus.access_count, 0);
    chk("mid_hit_count", bus.hit_count, 0);
    m_acc = 0;
    m_hit = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_cache_ready", bus.cache_ready, 0);
    end
    rst = 1'b0;
    run_access("post", 15'h1234, 1'b1, 0, 10'h08D, 3'h1, 15'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
